// File: rtl/mem_responder.sv
// mem_responder: wait-stated word RAM behind a MAR/MDR four-phase ready handshake
// Optional MEM_RANGE_CHECK_EN adds mem_err and blocks accesses at addresses >= DEPTH.
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_ready
`ifdef MEM_RANGE_CHECK_EN
  , output logic            mem_err
`endif
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next_state;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic lat_wr;
  logic [DATA_W-1:0] ram [DEPTH];
  logic req, fire, in_range;
  logic [IW-1:0] idx;
  assign req  = mem_read | mem_write;
  assign fire = (state == BUSY) && (cnt == 4'd0);
  assign idx  = lat_addr[IW-1:0];
`ifdef MEM_RANGE_CHECK_EN
  assign in_range = int'(lat_addr) < DEPTH;
`else
  assign in_range = 1'b1;
`endif
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && req) begin
        cnt      <= 4'(LATENCY - 1);
        lat_addr <= address;
        lat_data <= data_in;
        lat_wr   <= mem_write;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  always_comb begin
    next_state = state == IDLE ? (req ? BUSY : IDLE) :
                 state == BUSY ? (cnt == 4'd0 ? DONE : BUSY) :
                 (req ? DONE : IDLE);
  end
  always_comb begin
    mem_ready = state == DONE;
  end
  // The array has no reset; an aborted access never reaches BUSY with cnt==0.
  always_ff @(posedge clock) begin
    if (fire && lat_wr && in_range) ram[idx] <= lat_data;
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) data_out <= '0;
    else if (fire && !(lat_wr && in_range)) data_out <= in_range ? ram[idx] : '0;
  end
`ifdef MEM_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clock or posedge clear) begin
    if (clear) err_q <= 1'b0;
    else if (fire) err_q <= !in_range;
    else if (state == DONE && !req) err_q <= 1'b0;
  end
  assign mem_err = err_q;
`endif
endmodule
